// File: rtl/mem_pkg.sv
// Shared types for the MEM-stage store buffer: access-size encodings and the FIFO entry layout.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef struct packed {
      logic [29:0] word_addr;
      logic [3:0]  byteena;
      logic [31:0] data;
   } sb_entry_t;

   // Encoding 2'b11 is not a legal size and behaves as a word access.
   function automatic logic is_word(input logic [1:0] size);
      return size[1];
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: store byte enables and lane replication, load lane
// extraction with optional sign extension, and misalignment detection.
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  addr_lo_i,
   input  logic        sign_ext_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic [3:0]  byteena_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o,
   output logic        misalign_o
);

   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   assign rd_byte = rword_i[{addr_lo_i, 3'b000} +: 8];
   assign rd_half = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

   // Store data is copied into every lane so the enabled lane always holds it.
   always_comb begin
      byteena_o  = 4'b1111;
      wdata_o    = wdata_i;
      misalign_o = 1'b0;
      if (is_word(size_i)) begin
         misalign_o = (addr_lo_i != 2'b00);
      end else if (size_i == SZ_HALF) begin
         byteena_o  = addr_lo_i[1] ? 4'b1100 : 4'b0011;
         wdata_o    = {2{wdata_i[15:0]}};
         misalign_o = addr_lo_i[0];
      end else begin
         byteena_o  = 4'b0001 << addr_lo_i;
         wdata_o    = {4{wdata_i[7:0]}};
      end
   end

   always_comb begin
      rdata_o = rword_i;
      case (size_i)
         SZ_BYTE: rdata_o = {{24{sign_ext_i & rd_byte[7]}}, rd_byte};
         SZ_HALF: rdata_o = {{16{sign_ext_i & rd_half[15]}}, rd_half};
         SZ_WORD: rdata_o = rword_i;
         default: rdata_o = rword_i;
      endcase
   end

endmodule

// File: rtl/mem_store_buffer.sv
// MEM-stage store buffer: aligns requests, queues stores, arbitrates the data-memory port.
// Build option MEM_STORE_FWD_EN: serve loads from the youngest matching full-word entry.
module mem_store_buffer
   import mem_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        iCLK,
   input  logic        iRST_n,
   input  logic        iReq,
   input  logic        iWe,
   input  logic [1:0]  iSize,
   input  logic        iSignExt,
   input  logic [31:0] iAddress,
   input  logic [31:0] iWData,
   output logic        oStall,
   output logic        oMisalign,
   output logic [31:0] oRData,
   output logic        oEmpty,
   output logic [31:0] oMemAddress,
   output logic [3:0]  oMemByteEnable,
   output logic [31:0] oMemWriteData,
   output logic        oMemRead,
   output logic        oMemWrite,
   input  logic [31:0] iMemData
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE = 1;

   sb_entry_t        fifo_q [DEPTH];
   sb_entry_t        head;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] count;
   logic [IDX_W-1:0] wr_idx, rd_idx, scan_idx;
   logic             full, empty;

   logic [3:0]  lane_be;
   logic [31:0] lane_wdata;
   logic [31:0] ld_word;
   logic [31:0] ld_data;
   logic        misalign;

   logic        hit, fwd_ok;
   logic [31:0] fwd_data;
   logic        ld_req, st_req;
   logic        mem_read, load_done, push, pop, stall;

   assign wr_idx = wr_ptr_q[IDX_W-1:0];
   assign rd_idx = rd_ptr_q[IDX_W-1:0];
   assign count  = wr_ptr_q - rd_ptr_q;
   assign empty  = (wr_ptr_q == rd_ptr_q);
   assign full   = (wr_idx == rd_idx) && (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
   assign head   = fifo_q[rd_idx];

`ifdef MEM_STORE_FWD_EN
   assign ld_word = hit ? fwd_data : iMemData;
`else
   logic unused_fwd;
   assign unused_fwd = ^{fwd_ok, fwd_data};
   assign ld_word    = iMemData;
`endif

   mem_lane_align u_align (
      .size_i     (iSize),
      .addr_lo_i  (iAddress[1:0]),
      .sign_ext_i (iSignExt),
      .wdata_i    (iWData),
      .rword_i    (ld_word),
      .byteena_o  (lane_be),
      .wdata_o    (lane_wdata),
      .rdata_o    (ld_data),
      .misalign_o (misalign)
   );

   // Oldest-to-youngest scan, so the last hit is the youngest matching store.
   always_comb begin
      hit      = 1'b0;
      fwd_ok   = 1'b0;
      fwd_data = '0;
      scan_idx = '0;
      for (int k = 0; k < DEPTH; k++) begin
         scan_idx = rd_idx + IDX_W'(k);
         if ((PTR_W'(k) < count) && (fifo_q[scan_idx].word_addr == iAddress[31:2])) begin
            hit      = 1'b1;
            fwd_ok   = (fifo_q[scan_idx].byteena == 4'b1111);
            fwd_data = fifo_q[scan_idx].data;
         end
      end
   end

   // Handshake: the pipeline holds iReq and its payload while oStall=1; a request
   // is consumed in any cycle with iReq=1 and oStall=0 (misaligned ones are dropped).
   assign ld_req = iRST_n & iReq & ~iWe & ~misalign;
   assign st_req = iRST_n & iReq &  iWe & ~misalign;

   // The port drains only when no accepted request claims the cycle.
   always_comb begin
      mem_read  = 1'b0;
      load_done = 1'b0;
      push      = 1'b0;
      stall     = 1'b0;
      if (ld_req) begin
         if (!hit) begin
            mem_read  = 1'b1;
            load_done = 1'b1;
         end
`ifdef MEM_STORE_FWD_EN
         else if (fwd_ok) begin
            load_done = 1'b1;
         end
`endif
         else begin
            stall = 1'b1;
         end
      end
      if (st_req) begin
         if (full) begin
            stall = 1'b1;
         end else begin
            push = 1'b1;
         end
      end
      pop = iRST_n & ~empty & ~mem_read & ~push;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
   end

   always_ff @(posedge iCLK) begin
      if (!iRST_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge iCLK) begin
      if (push) begin
         fifo_q[wr_idx] <= '{word_addr: iAddress[31:2], byteena: lane_be, data: lane_wdata};
      end
   end

   always_comb begin
      oMemAddress    = '0;
      oMemByteEnable = '0;
      oMemWriteData  = '0;
      if (pop) begin
         oMemAddress    = {head.word_addr, 2'b00};
         oMemByteEnable = head.byteena;
         oMemWriteData  = head.data;
      end else if (mem_read) begin
         oMemAddress    = iAddress;
         oMemByteEnable = lane_be;
      end
   end

   assign oStall    = stall;
   assign oMisalign = iRST_n & iReq & misalign;
   assign oRData    = load_done ? ld_data : '0;
   assign oEmpty    = empty | ~iRST_n;
   assign oMemRead  = mem_read;
   assign oMemWrite = pop;

endmodule
